// File: rtl/irq_controller_vec_pkg.sv
// Shared constants, types and helpers for the vectored interrupt controller.
package irq_pkg;

   localparam logic [31:0]  MCAUSE_IRQ_BIT     = 32'h8000_0000;
   localparam int unsigned  CAUSE_BASE_DEFAULT = 16;
   localparam int unsigned  IRQ_ID_W           = 5;

   typedef logic [IRQ_ID_W-1:0] irq_id_t;

   // mcause value for a taken line: interrupt bit plus base-relative code
   function automatic logic [31:0] irq_cause(input int unsigned base, input irq_id_t id);
      return MCAUSE_IRQ_BIT | {1'b0, 31'(base + 32'(id))};
   endfunction

endpackage

// File: rtl/irq_controller_vec_if.sv
// Core/peripheral side signal bundle of the interrupt controller.
interface irq_controller_vec_if #(
   parameter int unsigned N_IRQ = 16
);
   logic              exception_i;
   logic [N_IRQ-1:0]  irq_req_i;
   logic [N_IRQ-1:0]  irq_en_i;
   logic              mie_i;
   logic              mret_i;
   logic              irq_o;
   logic [31:0]       irq_cause_o;
   logic [N_IRQ-1:0]  irq_ack_o;
   logic              irq_ret_o;
   logic [N_IRQ-1:0]  irq_pending_o;

   // Driver side: core trap logic and peripherals
   modport master (
      output exception_i, irq_req_i, irq_en_i, mie_i, mret_i,
      input  irq_o, irq_cause_o, irq_ack_o, irq_ret_o, irq_pending_o
   );

   // Controller side
   modport slave (
      input  exception_i, irq_req_i, irq_en_i, mie_i, mret_i,
      output irq_o, irq_cause_o, irq_ack_o, irq_ret_o, irq_pending_o
   );
endinterface

// File: rtl/irq_controller_vec_prio_enc.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic [N-1:0] i_eligible,
   output irq_id_t      o_id,
   output logic         o_valid
);

   // Scan high to low so the lowest set index is the final assignment
   always_comb begin
      o_id = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (i_eligible[k]) begin
            o_id = irq_id_t'(k);
         end
      end
   end

   // Any eligible line means an interrupt is available
   always_comb begin
      o_valid = |i_eligible;
   end

endmodule

// File: rtl/irq_controller_vec.sv
// Vectored machine-mode interrupt controller with single-level nesting.
module irq_controller_vec
   import irq_pkg::*;
#(
   parameter int unsigned       N_IRQ      = 16,
   parameter logic [N_IRQ-1:0]  EDGE_MASK  = '0,
   parameter int unsigned       CAUSE_BASE = CAUSE_BASE_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   irq_controller_vec_if.slave   bus
);

   logic [N_IRQ-1:0] r_req;
   logic [N_IRQ-1:0] r_pend;
   logic             r_exc_h;
   logic             r_irq_h;

   logic [N_IRQ-1:0] w_pend_nxt;
   logic             w_exc_h_nxt;
   logic             w_irq_h_nxt;

   logic [N_IRQ-1:0] w_pending;
   logic [N_IRQ-1:0] w_eligible;
   logic [N_IRQ-1:0] w_ack;
   irq_id_t          w_id;
   logic             w_valid;
   logic             w_busy;
   logic             w_irq;
   logic             w_ret;

   // Edge lines report their latch, level lines pass the raw request
   always_comb begin
      w_pending  = (EDGE_MASK & r_pend) | (~EDGE_MASK & bus.irq_req_i);
      w_eligible = w_pending & bus.irq_en_i;
   end

   irq_prio_enc #(
      .N (N_IRQ)
   ) u_prio (
      .i_eligible (w_eligible),
      .o_id       (w_id),
      .o_valid    (w_valid)
   );

   // Take/return decision; an exception in flight or an active handler blocks entry
   always_comb begin
      w_busy = r_irq_h | bus.exception_i | r_exc_h;
      w_irq  = rst_ni & bus.mie_i & w_valid & ~w_busy;
      w_ret  = rst_ni & bus.mret_i & ~(bus.exception_i | r_exc_h);
      w_ack  = '0;
      if (w_irq) begin
         w_ack = N_IRQ'(1) << w_id;
      end
   end

   // Next state: a new edge beats the acknowledge clear in the same cycle
   always_comb begin
      w_pend_nxt  = EDGE_MASK & ((bus.irq_req_i & ~r_req) | (r_pend & ~w_ack));
      w_exc_h_nxt = ~bus.mret_i & (bus.exception_i | r_exc_h);
      w_irq_h_nxt = (w_irq | r_irq_h) & ~w_ret;
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_req   <= '0;
         r_pend  <= '0;
         r_exc_h <= 1'b0;
         r_irq_h <= 1'b0;
      end else begin
         r_req   <= bus.irq_req_i;
         r_pend  <= w_pend_nxt;
         r_exc_h <= w_exc_h_nxt;
         r_irq_h <= w_irq_h_nxt;
      end
   end

   // Outputs are combinational and forced quiet while reset is asserted
   always_comb begin
      bus.irq_o         = w_irq;
      bus.irq_cause_o   = '0;
      bus.irq_ack_o     = w_ack;
      bus.irq_ret_o     = w_ret;
      bus.irq_pending_o = '0;
      if (w_irq) begin
         bus.irq_cause_o = irq_cause(CAUSE_BASE, w_id);
      end
      if (rst_ni) begin
         bus.irq_pending_o = w_pending;
      end
   end

endmodule

// File: tb/tb_irq_controller_vec.sv
// Randomised and directed bench for irq_controller_vec against a behavioural model.
module tb_irq_controller_vec;
   import irq_pkg::*;

   localparam int unsigned N  = 4;
   localparam logic [3:0]  EM = 4'b1100;
   localparam int unsigned CB = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   irq_controller_vec_if #(.N_IRQ(N)) bus ();

   irq_controller_vec #(
      .N_IRQ      (N),
      .EDGE_MASK  (EM),
      .CAUSE_BASE (CB)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: what the spec says the controller remembers
   logic [3:0] m_prev_req;
   logic [3:0] m_latched;
   bit         m_in_exc;
   bit         m_in_irq;

   // Observed outputs of the last step, for literal checks
   logic        o_irq, o_ret;
   logic [31:0] o_cause;
   logic [3:0]  o_ack, o_pend;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, want, $time);
      end
   endtask

   task automatic model_reset();
      m_prev_req = '0;
      m_latched  = '0;
      m_in_exc   = 0;
      m_in_irq   = 0;
   endtask

   // One clock cycle: drive, compare against model, advance model
   task automatic step(input bit exc, input logic [3:0] req, input logic [3:0] en,
                       input bit mie, input bit mret);
      logic [3:0]  pend;
      logic [31:0] e_cause;
      logic [3:0]  e_ack;
      int          sel;
      bit          e_irq, e_ret;
      @(negedge clk);
      rst_n            = 1'b1;
      bus.exception_i  = exc;
      bus.irq_req_i    = req;
      bus.irq_en_i     = en;
      bus.mie_i        = mie;
      bus.mret_i       = mret;
      #1;
      for (int k = 0; k < 4; k++) pend[k] = EM[k] ? m_latched[k] : req[k];
      sel = -1;
      for (int k = 0; k < 4; k++) if (sel < 0 && pend[k] && en[k]) sel = k;
      e_irq   = mie && (sel >= 0) && !(m_in_irq || exc || m_in_exc);
      e_ret   = mret && !(exc || m_in_exc);
      e_cause = e_irq ? (32'h8000_0000 + CB + 32'(sel)) : 32'h0;
      e_ack   = e_irq ? 4'(1 << sel) : 4'h0;
      o_irq = bus.irq_o; o_ret = bus.irq_ret_o; o_cause = bus.irq_cause_o;
      o_ack = bus.irq_ack_o; o_pend = bus.irq_pending_o;
      check_eq("irq_o",     32'(o_irq),   32'(e_irq));
      check_eq("cause",     o_cause,      e_cause);
      check_eq("ack",       32'(o_ack),   32'(e_ack));
      check_eq("ret",       32'(o_ret),   32'(e_ret));
      check_eq("pending",   32'(o_pend),  32'(pend));
      for (int k = 0; k < 4; k++) begin
         if (EM[k]) begin
            if (req[k] && !m_prev_req[k]) m_latched[k] = 1'b1;
            else if (e_ack[k])            m_latched[k] = 1'b0;
         end
      end
      m_prev_req = req;
      if (mret)     m_in_exc = 0;
      else if (exc) m_in_exc = 1;
      if (e_ret)      m_in_irq = 0;
      else if (e_irq) m_in_irq = 1;
      @(posedge clk);
   endtask

   // Assert reset mid-cycle with the given request lines held high
   task automatic do_reset(input string tag, input logic [3:0] req);
      @(negedge clk);
      bus.irq_req_i   = req;
      bus.exception_i = 1'b0;
      bus.mret_i      = 1'b1;
      bus.mie_i       = 1'b1;
      bus.irq_en_i    = 4'hF;
      rst_n           = 1'b0;
      #1;
      check_eq({tag, "_irq"},   32'(bus.irq_o),         32'h0);
      check_eq({tag, "_cause"}, bus.irq_cause_o,        32'h0);
      check_eq({tag, "_ack"},   32'(bus.irq_ack_o),     32'h0);
      check_eq({tag, "_ret"},   32'(bus.irq_ret_o),     32'h0);
      check_eq({tag, "_pend"},  32'(bus.irq_pending_o), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      bus.mret_i = 1'b0;
   endtask

   initial begin
      bus.exception_i = 1'b0;
      bus.irq_req_i   = '0;
      bus.irq_en_i    = 4'hF;
      bus.mie_i       = 1'b1;
      bus.mret_i      = 1'b0;
      model_reset();

      do_reset("rst0", 4'b0011);

      // Level line: same-cycle take, blocked while in service
      step(0, 4'b0011, 4'hF, 1, 0);
      check_eq("lvl_cause", o_cause, 32'h8000_0010);
      check_eq("lvl_ack",   32'(o_ack), 32'h1);
      step(0, 4'b0011, 4'hF, 1, 0);
      check_eq("lvl_hold",  32'(o_irq), 32'h0);

      // Return then re-entry on the next line
      step(0, 4'b0010, 4'hF, 1, 1);
      check_eq("ret_now",   32'(o_ret), 32'h1);
      check_eq("ret_noirq", 32'(o_irq), 32'h0);
      step(0, 4'b0010, 4'hF, 1, 0);
      check_eq("reent_cause", o_cause, 32'h8000_0011);
      check_eq("reent_ack",   32'(o_ack), 32'h2);

      // Edge pulse while in service is latched until taken
      step(0, 4'b0100, 4'hF, 1, 0);
      step(0, 4'b0000, 4'hF, 1, 0);
      check_eq("edge_latch", 32'(o_pend), 32'h4);
      step(0, 4'b0000, 4'hF, 1, 1);
      step(0, 4'b0000, 4'hF, 1, 0);
      check_eq("edge_cause", o_cause, 32'h8000_0012);
      step(0, 4'b0000, 4'hF, 1, 0);
      check_eq("edge_clr", 32'(o_pend), 32'h0);
      step(0, 4'b0000, 4'hF, 1, 1);

      // Exception beats a request; first mret only clears the exception
      step(1, 4'b0001, 4'hF, 1, 0);
      check_eq("exc_block", 32'(o_irq), 32'h0);
      step(0, 4'b0001, 4'hF, 1, 1);
      check_eq("exc_mret", 32'(o_ret), 32'h0);
      step(0, 4'b0001, 4'hF, 1, 0);
      check_eq("exc_after", o_cause, 32'h8000_0010);
      step(0, 4'b0000, 4'hF, 1, 1);

      // Masking keeps the latch; exception during service holds irq_h
      step(0, 4'b1000, 4'hF, 0, 0);
      step(0, 4'b0000, 4'hF, 0, 0);
      check_eq("mask_pend", 32'(o_pend), 32'h8);
      check_eq("mask_irq",  32'(o_irq),  32'h0);
      step(0, 4'b0000, 4'b0111, 1, 0);
      check_eq("en_block",  32'(o_irq),  32'h0);
      step(0, 4'b0000, 4'hF, 1, 0);
      check_eq("mask_cause", o_cause, 32'h8000_0013);
      step(1, 4'b0000, 4'hF, 1, 0);
      step(0, 4'b0000, 4'hF, 1, 1);
      check_eq("nest_ret1", 32'(o_ret), 32'h0);
      step(0, 4'b0000, 4'hF, 1, 1);
      check_eq("nest_ret2", 32'(o_ret), 32'h1);

      // Reset while in service with both edge lines latched
      step(0, 4'b0001, 4'hF, 1, 0);
      step(0, 4'b1100, 4'hF, 1, 0);
      step(0, 4'b0000, 4'hF, 1, 0);
      check_eq("pre_rst_pend", 32'(o_pend), 32'hC);
      do_reset("rst1", 4'b0000);
      step(0, 4'b0000, 4'hF, 1, 0);
      check_eq("post_rst_pend", 32'(o_pend), 32'h0);
      step(0, 4'b0000, 4'hF, 1, 1);
      check_eq("post_rst_ret", 32'(o_ret), 32'h1);
      check_eq("post_rst_irq", 32'(o_irq), 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [3:0] rq, en;
         bit ex, mr, mi;
         if (i % 150 == 149) begin
            do_reset("rst_rnd", 4'($urandom_range(0, 15)));
         end
         rq = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         ex = ($urandom_range(0, 9) == 0);
         mr = ($urandom_range(0, 4) == 0);
         mi = ($urandom_range(0, 7) != 0);
         step(ex, rq, en, mi, mr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/irq_controller_vec.md
Name: irq_controller_vec

Overview:
- Parametrised successor to the single-line machine-mode interrupt controller.
- Accepts N_IRQ external request lines. Each line is level or edge type, with a per-line enable. Lowest-index-first fixed priority.
- Keeps the single-level nesting rule: an exception in flight, or an interrupt already in service, blocks new interrupts until mret.
- Sits between the peripheral IRQ lines and the CSR/core trap logic. Supplies irq_o and mcause to the core, and a one-hot ack back to peripherals.

Parameters:
- N_IRQ, 16, number of request lines (1..32).
- EDGE_MASK, '0 (N_IRQ bits), per-line type: 1 = rising-edge latched, 0 = level.
- CAUSE_BASE, 16, mcause code of line 0; line k reports CAUSE_BASE+k.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- exception_i  in  1  synchronous exception raised this cycle.
- irq_req_i  in  N_IRQ  peripheral request lines.
- irq_en_i  in  N_IRQ  per-line enable (mie bits).
- mie_i  in  1  global enable (mstatus.MIE).
- mret_i  in  1  mret executed this cycle.
- irq_o  out  1  take interrupt this cycle.
- irq_cause_o  out  32  mcause value; valid when irq_o=1.
- irq_ack_o  out  N_IRQ  one-hot id of the taken line, only when irq_o=1.
- irq_ret_o  out  1  interrupt return this cycle.
- irq_pending_o  out  N_IRQ  current pending vector.

Behaviour:
- Clock and reset: single clock domain, clk_i. rst_ni is asynchronous active-low. While rst_ni=0, all state regs are cleared and irq_o, irq_ack_o, irq_ret_o, irq_cause_o, irq_pending_o are forced to 0.
- State regs: req_q[N_IRQ], pend_q[N_IRQ] (edge lines only), exc_h, irq_h.
- Pending vector:
  - pending[k] = EDGE_MASK[k] ? pend_q[k] : irq_req_i[k].
  - Edge line: pend_q[k] sets when irq_req_i[k] & ~req_q[k]. It clears on the edge where irq_ack_o[k]=1.
  - If a set and a clear occur in the same cycle, set wins.
  - req_q resets to 0, so an edge line that is high when reset releases counts as an edge.
- Selection: eligible = pending & irq_en_i. id = lowest set index of eligible; valid = |eligible.
- busy = irq_h | exception_i | exc_h.
- Outputs (combinational, same cycle):
  - irq_o = mie_i & valid & ~busy.
  - irq_cause_o = irq_o ? {1'b1, 31'(CAUSE_BASE+id)} : 0.
  - irq_ack_o = irq_o ? (1<<id) : 0.
  - irq_ret_o = mret_i & ~(exception_i | exc_h).
- State updates:
  - exc_h <= ~mret_i & (exception_i | exc_h).
  - irq_h <= (irq_o | irq_h) & ~irq_ret_o.
- Level lines are never latched. The peripheral must hold the request until serviced. A level request that drops before being taken is lost.
- Simultaneous events:
  - mret_i with an eligible request: irq_h is still 1 in that cycle, so there is no irq_o. The earliest re-entry is the next cycle.
  - exception_i with an eligible request: exception wins, irq_o=0.
  - Exception while irq_h=1: irq_h is held. The first mret clears only exc_h (irq_ret_o=0). The second mret returns from the interrupt.
  - mret_i with neither an exception nor an interrupt in service: irq_ret_o=1, harmless.
- Masking: mie_i=0 or irq_en_i[k]=0 blocks taking the interrupt but does not clear pend_q.
- Latency: request-to-irq_o is 0 cycles for level lines and 1 cycle for edge lines (edge registered into pend_q).

Decomposition:
- Package irq_pkg holds:
  - MCAUSE_IRQ_BIT = 32'h8000_0000.
  - Default CAUSE_BASE.
  - Typedef irq_id_t = logic [4:0].
- Sub-module irq_prio_enc (parameter N): eligible vector in; id and valid out; lowest index wins.

Test Plan (N_IRQ=4, EDGE_MASK=4'b1100, CAUSE_BASE=16, mie_i=1, irq_en_i=4'hF):
- Level: irq_req_i=4'b0011 -> same cycle irq_o=1, cause 0x8000_0010, ack 4'b0001. Next cycle irq_o=0 while irq_req_i held.
- Return: mret_i=1 with line 0 dropped -> irq_ret_o=1 that cycle. Next cycle irq_o=1, cause 0x8000_0011, ack 4'b0010.
- Edge: 1-cycle pulse on line 2 while irq_h=1 -> irq_pending_o=4'b0100 holds. After mret: irq_o=1, cause 0x8000_0012. Cycle after that, irq_pending_o=0.
- Exception: exception_i=1 with line 0 high -> irq_o=0. Next mret: irq_ret_o=0, exc_h cleared. Following cycle irq_o=1, cause 0x8000_0010.
- Masking: mie_i=0, edge on line 3 -> irq_pending_o[3]=1, no irq_o. Then mie_i=1 -> irq_o=1, cause 0x8000_0013. irq_en_i[3]=0 also blocks it.
- Reset mid-service: rst_ni=0 with irq_h=1 and pend_q=4'b1100 -> all outputs 0 immediately. After release with irq_req_i=0: irq_pending_o=0 and mret gives irq_ret_o=1 with no irq_o.
